// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the byte-serial load/store unit.
package lsu_pkg;

    // Access size as carried on req_size.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } size_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    // Number of bytes moved for a size; the illegal size reports 4 but is never transferred.
    function automatic logic [2:0] size_bytes(input size_e size);
        case (size)
            SZ_B:    return 3'd1;
            SZ_H:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [1:0] align_mask(input size_e size);
        case (size)
            SZ_B:    return 2'b00;
            SZ_H:    return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // Move the N-byte datum to the top of the word so the MSB byte goes out first.
    function automatic logic [31:0] left_justify(input logic [31:0] data, input size_e size);
        case (size)
            SZ_B:    return {data[7:0], 24'h0};
            SZ_H:    return {data[15:0], 16'h0};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of the assembled load data to 32 bits.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [31:0] data,
    input  size_e       size,
    input  logic        is_signed,
    output logic [31:0] rdata
);

    // Select the low 8N bits and extend them according to the captured signedness.
    always_comb begin
        // NOTE: default assignment first so no path leaves rdata unassigned (no latch).
        rdata = data;
        case (size)
            SZ_B:    rdata = {{24{is_signed & data[7]}}, data[7:0]};
            SZ_H:    rdata = {{16{is_signed & data[15]}}, data[15:0]};
            default: rdata = data;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer: splits a byte/half/word request into
// big-endian byte accesses to a byte-wide memory and reassembles loads.
module lsu_byte_seq
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    state_e      state;
    size_e       size_q;
    logic        write_q;
    logic        signed_q;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;   // left-justified store data, shifted out MSB first
    logic [31:0] asm_q;     // load assembly register
    logic [1:0]  cnt;       // byte index k within the transfer

    size_e       req_size_e;
    logic [2:0]  req_n;
    logic [32:0] req_end;
    logic        req_err;
    logic [1:0]  last_k;
    logic        xfer;
    logic [31:0] ext_data;

    assign req_size_e = size_e'(req_size);
    assign req_n      = size_bytes(req_size_e);
    // 33-bit sum so an address near 2^32 cannot wrap into the legal range.
    assign req_end    = {1'b0, req_addr} + 33'(req_n);
    assign req_err    = (req_size_e == SZ_X)
                     || ((req_addr[1:0] & align_mask(req_size_e)) != 2'b00)
                     || (req_end > 33'(MEM_BYTES));

    assign last_k     = 2'(size_bytes(size_q) - 3'd1);
    assign xfer       = (state == XFER);

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = (state == RESP && !err_q && !write_q) ? ext_data : 32'h0;

    assign mem_re     = xfer && !write_q;
    assign mem_we     = xfer && write_q;
    assign mem_addr   = xfer ? (addr_q + 32'(cnt)) : 32'h0;
    assign mem_wdata  = (xfer && write_q) ? wdata_q[31:24] : 8'h00;

    lsu_extend u_extend (
        .data      (asm_q),
        .size      (size_q),
        .is_signed (signed_q),
        .rdata     (ext_data)
    );

    // Sequencer FSM: capture at handshake, step one byte per XFER cycle, pulse RESP.
    always_ff @(posedge clk) begin
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            cnt      <= 2'd0;
            asm_q    <= 32'h0;
            size_q   <= SZ_B;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        size_q   <= req_size_e;
                        write_q  <= req_write;
                        signed_q <= req_signed;
                        err_q    <= req_err;
                        addr_q   <= req_addr;
                        wdata_q  <= left_justify(req_wdata, req_size_e);
                        cnt      <= 2'd0;
                        asm_q    <= 32'h0;
                        state    <= req_err ? RESP : XFER;
                    end
                end
                XFER: begin
                    if (!write_q) begin
                        asm_q <= {asm_q[23:0], mem_rdata};
                    end
                    wdata_q <= {wdata_q[23:0], 8'h00};
                    if (cnt == last_k) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// Self-checking bench for lsu_byte_seq: a request-level reference model
// predicts every response and every byte access; directed cases pin the
// model with hand-computed values.
module tb_lsu_byte_seq;

    localparam int MEM_BYTES = 48;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    lsu_byte_seq #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Byte-wide memory attached to the DUT.
    logic [7:0] mem [MEM_BYTES];
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32'(MEM_BYTES)) mem[int'(mem_addr)] <= mem_wdata;
    end
    always_comb begin
        mem_rdata = 8'h00;
        if (mem_re && mem_addr < 32'(MEM_BYTES)) mem_rdata = mem[int'(mem_addr)];
    end

    // Reference model state.
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] rdata;
    } resp_t;
    typedef struct {
        int          due;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
    } op_t;

    logic [7:0] ref_mem [MEM_BYTES];
    resp_t exp_q[$];
    op_t   op_q[$];
    bit    armed = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Predict the outcome of a request accepted in cycle 'cyc'.
    task automatic model_accept();
        int          n;
        bit          e;
        logic [31:0] v;
        resp_t       r;
        op_t         o;
        case (req_size)
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        e = (n == 0);
        if (!e) e = (int'(req_addr % 32'(n)) != 0) || (longint'(req_addr) + n > MEM_BYTES);
        if (e) begin
            r.due = cyc + 1; r.err = 1'b1; r.rdata = 32'h0;
            exp_q.push_back(r);
        end else begin
            v = 32'h0;
            for (int k = 0; k < n; k++) begin
                o.due   = cyc + 1 + k;
                o.we    = req_write;
                o.addr  = req_addr + 32'(k);
                o.wdata = 8'(req_wdata >> (8 * (n - 1 - k)));
                op_q.push_back(o);
                v = (v << 8) | 32'(ref_mem[int'(req_addr) + k]);
            end
            if (req_signed && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            r.due = cyc + n + 1; r.err = 1'b0; r.rdata = req_write ? 32'h0 : v;
            exp_q.push_back(r);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (armed) begin
            logic exp_rv;
            op_t  o;
            exp_rv = (exp_q.size() > 0 && exp_q[0].due == cyc);
            check("req_ready", 32'(req_ready), 32'(exp_q.size() == 0));
            check("resp_valid", 32'(resp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check("resp_err", 32'(resp_err), 32'(exp_q[0].err));
                check("resp_rdata", resp_rdata, exp_q[0].rdata);
                void'(exp_q.pop_front());
            end
            if (op_q.size() > 0 && op_q[0].due == cyc) begin
                o = op_q.pop_front();
                check("mem_we", 32'(mem_we), 32'(o.we));
                check("mem_re", 32'(mem_re), 32'(!o.we));
                check("mem_addr", mem_addr, o.addr);
                if (o.we) begin
                    check("mem_wdata", 32'(mem_wdata), 32'(o.wdata));
                    ref_mem[int'(o.addr)] = o.wdata;
                end
            end else begin
                check("idle_we", 32'(mem_we), 32'h0);
                check("idle_re", 32'(mem_re), 32'h0);
                check("idle_addr", mem_addr, 32'h0);
                check("idle_wdata", 32'(mem_wdata), 32'h0);
            end
            if (rst) begin
                exp_q.delete();
                op_q.delete();
            end else if (req_valid && req_ready) begin
                model_accept();
            end
        end
    end

    // One request: returns latency, data, error flag and number of byte accesses.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output int acts);
        int hs;
        @(posedge clk); #1;
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        hs = -1;
        for (int i = 0; i < 20 && hs < 0; i++) begin
            @(negedge clk);
            if (req_ready) hs = cyc;
        end
        if (hs < 0) check("handshake_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = -1; rd = 32'h0; er = 1'b0; acts = 0;
        for (int i = 0; i < 20 && lat < 0 && hs >= 0; i++) begin
            @(negedge clk);
            if (mem_we || mem_re) acts++;
            if (resp_valid) begin
                lat = cyc - hs; rd = resp_rdata; er = resp_err;
            end
        end
        if (lat < 0) check("resp_timeout", 32'h0, 32'h1);
    endtask

    int          lat, acts;
    logic [31:0] rd;
    logic        er;
    int          hs_cyc [4];

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            logic [7:0] v;
            v = 8'(i * 17 + 5);
            if (i == 2)  v = 8'h5A;
            if (i == 3)  v = 8'h80;
            if (i == 44) v = 8'hC0;
            if (i == 45) v = 8'hFF;
            if (i == 46) v = 8'hEE;
            if (i == 47) v = 8'h42;
            mem[i] <= v;
            ref_mem[i] = v;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; armed = 1'b1;

        // Out-of-reset outputs.
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_re", 32'(mem_re), 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);

        // Byte loads of 0x80.
        do_req(1'b0, 2'b00, 1'b1, 32'd3, 32'h0, lat, rd, er, acts);
        check("lb_signed_data", rd, 32'hFFFFFF80);
        check("lb_signed_lat", 32'(lat), 32'd2);
        do_req(1'b0, 2'b00, 1'b0, 32'd3, 32'h0, lat, rd, er, acts);
        check("lb_unsigned_data", rd, 32'h00000080);
        check("lb_unsigned_lat", 32'(lat), 32'd2);

        // Word store then load.
        do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, lat, rd, er, acts);
        check("sw_lat", 32'(lat), 32'd5);
        check("sw_rdata", rd, 32'h0);
        check("sw_acts", 32'(acts), 32'd4);
        check("sw_mem8", 32'(mem[8]), 32'hDE);
        check("sw_mem9", 32'(mem[9]), 32'hAD);
        check("sw_mem10", 32'(mem[10]), 32'hBE);
        check("sw_mem11", 32'(mem[11]), 32'hEF);
        do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, lat, rd, er, acts);
        check("lw_data", rd, 32'hDEADBEEF);
        check("lw_lat", 32'(lat), 32'd5);

        // Half store, neighbours untouched.
        do_req(1'b1, 2'b01, 1'b0, 32'd6, 32'h1234ABCD, lat, rd, er, acts);
        check("sh_lat", 32'(lat), 32'd3);
        check("sh_mem6", 32'(mem[6]), 32'hAB);
        check("sh_mem7", 32'(mem[7]), 32'hCD);
        check("sh_mem4", 32'(mem[4]), 32'h49);
        check("sh_mem5", 32'(mem[5]), 32'h5A);
        check("sh_mem8", 32'(mem[8]), 32'hDE);
        do_req(1'b0, 2'b01, 1'b1, 32'd6, 32'h0, lat, rd, er, acts);
        check("lh_signed_data", rd, 32'hFFFFABCD);

        // Error requests: one-cycle latency, no memory activity.
        do_req(1'b1, 2'b10, 1'b0, 32'd2, 32'h55555555, lat, rd, er, acts);
        check("err_misalign_err", 32'(er), 32'h1);
        check("err_misalign_lat", 32'(lat), 32'd1);
        check("err_misalign_acts", 32'(acts), 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, lat, rd, er, acts);
        check("err_size_err", 32'(er), 32'h1);
        check("err_size_lat", 32'(lat), 32'd1);
        check("err_size_rdata", rd, 32'h0);
        do_req(1'b0, 2'b10, 1'b0, 32'd46, 32'h0, lat, rd, er, acts);
        check("err_range_err", 32'(er), 32'h1);
        check("err_range_acts", 32'(acts), 32'd0);
        do_req(1'b0, 2'b00, 1'b0, 32'd48, 32'h0, lat, rd, er, acts);
        check("err_byte48_err", 32'(er), 32'h1);

        // Upper boundary legal accesses.
        do_req(1'b0, 2'b10, 1'b0, 32'd44, 32'h0, lat, rd, er, acts);
        check("lw44_err", 32'(er), 32'h0);
        check("lw44_data", rd, 32'hC0FFEE42);
        do_req(1'b0, 2'b00, 1'b0, 32'd47, 32'h0, lat, rd, er, acts);
        check("lb47_data", rd, 32'h00000042);

        // Reset after the second XFER cycle of a word store at 0.
        @(posedge clk); #1;
        req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'd0; req_wdata = 32'h11223344; req_valid = 1'b1;
        @(negedge clk);
        check("abort_hs_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1 req_valid = 1'b0;      // first XFER cycle
        @(posedge clk); #1 rst = 1'b1;            // second XFER cycle
        @(posedge clk); #1 rst = 1'b0;
        acts = 0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_we) acts++;
            if (resp_valid) lat++;
        end
        check("abort_no_we", 32'(acts), 32'd0);
        check("abort_no_resp", 32'(lat), 32'd0);
        check("abort_mem0", 32'(mem[0]), 32'h11);
        check("abort_mem1", 32'(mem[1]), 32'h22);
        check("abort_mem2", 32'(mem[2]), 32'h5A);
        check("abort_mem3", 32'(mem[3]), 32'h80);
        do_req(1'b0, 2'b10, 1'b0, 32'd0, 32'h0, lat, rd, er, acts);
        check("post_abort_data", rd, 32'h11225A80);
        check("post_abort_lat", 32'(lat), 32'd5);

        // Back-to-back byte loads with req_valid held high.
        @(posedge clk); #1;
        req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'd20; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit got;
            got = 1'b0;
            hs_cyc[i] = -100;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                if (req_ready) got = 1'b1;
            end
            if (!got) check("b2b_hs_timeout", 32'h0, 32'h1);
            else hs_cyc[i] = cyc;
            @(posedge clk); #1;
            req_addr  = 32'd21 + 32'(i);
            req_valid = (i < 3);
        end
        for (int i = 0; i < 3; i++) check("b2b_interval", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd3);

        repeat (6) @(negedge clk);
        check("drain_resp", 32'(exp_q.size()), 32'd0);
        check("drain_ops", 32'(op_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
